fetch_stall_ctrl: RTL and testbench
===================================

// Module: fetch_stall_ctrl
// PURPOSE
//  Sequences the IF stage and the IF/ID pipeline register of the 5-stage pipeline.
//  Generates PC write, IF/ID write and IF/ID flush enables from hazard, redirect,
//  memory-stall and halt events. Tracks instruction-cache misses with a small FSM.
//  Sits between the hazard unit, the fetch memory and the IF/ID register.
// PARAMETERS
//  RST_BUBBLES  1   NOP cycles forced into IF/ID after reset release (1..7)
//  CNT_W        16  width of the stall-cycle counter (STALL_CNT_EN only)
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  rst           in   1      asynchronous, active-high reset
//  imem_stall    in   1      fetch memory cannot deliver the word this cycle (miss/busy)
//  imem_done     in   1      fetch memory delivers the word for an outstanding miss
//  dmem_stall    in   1      data memory busy; freeze the front end
//  ld_use        in   1      load-use hazard detected in ID
//  br_taken      in   1      taken branch/jump resolved in EX; PC mux selects target
//  halt_id       in   1      HALT instruction decoded in ID
//  pc_wrt        out  1      PC register write enable
//  wrt_IF_ID     out  1      IF/ID register write enable
//  flush_IF_ID   out  1      IF/ID input mux selects NOP_INSTR instead of fetched word
//  bubble_ID_EX  out  1      insert bubble into ID/EX (load-use)
//  imem_req      out  1      fetch memory read request
//  halted        out  1      core halted; high until reset
//  stall_cycles  out  CNT_W  stalled-cycle count (STALL_CNT_EN only)
// BEHAVIOUR
//  - State registered; outputs combinational from state and inputs.
//  - Reset (async): state=RST_BUB, bub_cnt=RST_BUBBLES, redir_pend=0. While in reset:
//    pc_wrt=0, wrt_IF_ID=1, flush_IF_ID=1, bubble_ID_EX=0, imem_req=0, halted=0.
//  - RST_BUB: pc_wrt=0, wrt=1, flush=1, imem_req=0; bub_cnt decrements; at 1 -> RUN.
//  - RUN: imem_req=1. Priority per cycle, highest first:
//    1 br_taken:   pc_wrt=1, wrt=1, flush=1; stay RUN (imem_stall ignored this cycle).
//    2 dmem_stall: pc_wrt=0, wrt=0, flush=0; stay RUN.
//    3 halt_id:    pc_wrt=0, wrt=0; -> HALT.
//    4 ld_use:     pc_wrt=0, wrt=0, bubble_ID_EX=1; stay RUN.
//    5 imem_stall: pc_wrt=0, wrt=1, flush=1; -> IWAIT.
//    6 otherwise:  pc_wrt=1, wrt=1, flush=0.
//  - IWAIT: imem_req=1, pc_wrt=0, wrt=1, flush=1 every cycle (NOPs flow downstream).
//    br_taken in IWAIT: pc_wrt=1 (target captured), redir_pend<=1; stay IWAIT.
//    dmem_stall in IWAIT: wrt=0 (hold IF/ID); miss still tracked.
//    imem_done: if redir_pend, discard word (flush=1, pc_wrt=0), clear redir_pend;
//    else pc_wrt=1, wrt=1, flush=0. -> RUN either way.
//    imem_done and br_taken in same cycle: word discarded, pc_wrt=1, -> RUN.
//  - HALT: pc_wrt=0, wrt=0, imem_req=0, halted=1; terminal until rst.
//  - imem_done outside IWAIT is ignored. Mid-operation reset aborts any miss.
//  - Exactly one of {wrt=0 hold, flush NOP, normal load} holds per cycle.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_cycles counts cycles with pc_wrt=0 in RUN/IWAIT,
//    saturating at all-ones; reset to 0; frozen in HALT.
//  STALL_CNT_EN undefined: port absent, no counter logic.
// STRUCTURE
//  Package fetch_ctrl_pkg: state encoding (RST_BUB=2'd0, RUN=2'd1, IWAIT=2'd2,
//    HALT=2'd3), NOP_INSTR=16'h0800.
//  Sub-module sat_counter (CNT_W) instantiated only under STALL_CNT_EN.
// TESTING
//  1 Release rst, RST_BUBBLES=2 -> flush=1 for 2 cycles, then pc_wrt=1, imem_req=1.
//  2 RUN, imem_stall 3 cycles then imem_done -> 3 NOP loads, then pc_wrt=1 flush=0.
//  3 IWAIT, br_taken cycle 1, imem_done cycle 3 -> pc_wrt=1 cycle 1, word flushed cycle 3.
//  4 RUN, ld_use+dmem_stall together -> hold only (bubble_ID_EX=0); ld_use alone -> bubble=1.
//  5 halt_id -> halted=1 next cycle, pc_wrt=0 forever; rst -> RST_BUB.
//  6 STALL_CNT_EN, CNT_W=2, 5 stall cycles -> stall_cycles=3 (saturated).

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch stall controller: controller states and the NOP word.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_BUB = 2'd0,
    RUN     = 2'd1,
    IWAIT   = 2'd2,
    HALT    = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used to accumulate stalled fetch cycles.
// Only compiled when STALL_CNT_EN is defined.
`ifdef STALL_CNT_EN
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/fetch_stall_ctrl.sv
// IF stage / IF-ID register sequencer: PC write, IF/ID write/flush and miss tracking.
// Optional stalled-cycle counter is built when STALL_CNT_EN is defined.
module fetch_stall_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int RST_BUBBLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic             dmem_stall,
  input  logic             ld_use,
  input  logic             br_taken,
  input  logic             halt_id,
  output logic             pc_wrt,
  output logic             wrt_IF_ID,
  output logic             flush_IF_ID,
  output logic             bubble_ID_EX,
  output logic             imem_req,
`ifdef STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
`endif
  output logic             halted
);

  // state   | meaning
  // RST_BUB | post-reset NOP injection, PC frozen
  // RUN     | normal fetch, hazard/redirect priority applies
  // IWAIT   | i-cache miss outstanding, NOPs flow downstream
  // HALT    | core halted until reset

  if (RST_BUBBLES < 1 || RST_BUBBLES > 7 || CNT_W < 1) begin : g_bad_param
    $error("fetch_stall_ctrl: RST_BUBBLES must be 1..7 and CNT_W >= 1");
  end

  fetch_state_e state_q, state_d;
  logic [2:0]   bub_cnt_q, bub_cnt_d;
  logic         redir_pend_q, redir_pend_d;

  always_comb begin
    state_d      = state_q;
    bub_cnt_d    = bub_cnt_q;
    redir_pend_d = redir_pend_q;
    pc_wrt       = 1'b0;
    wrt_IF_ID    = 1'b0;
    flush_IF_ID  = 1'b0;
    bubble_ID_EX = 1'b0;
    imem_req     = 1'b0;
    halted       = 1'b0;
    case (state_q)
      RST_BUB: begin
        wrt_IF_ID   = 1'b1;
        flush_IF_ID = 1'b1;
        if (bub_cnt_q <= 3'd1) state_d = RUN;
        else                   bub_cnt_d = bub_cnt_q - 3'd1;
      end
      RUN: begin
        imem_req = 1'b1;
        if (br_taken) begin
          pc_wrt      = 1'b1;
          wrt_IF_ID   = 1'b1;
          flush_IF_ID = 1'b1;
        end else if (dmem_stall) begin
          state_d = RUN;
        end else if (halt_id) begin
          state_d = HALT;
        end else if (ld_use) begin
          bubble_ID_EX = 1'b1;
        end else if (imem_stall) begin
          wrt_IF_ID   = 1'b1;
          flush_IF_ID = 1'b1;
          state_d     = IWAIT;
        end else begin
          pc_wrt    = 1'b1;
          wrt_IF_ID = 1'b1;
        end
      end
      IWAIT: begin
        imem_req    = 1'b1;
        wrt_IF_ID   = 1'b1;
        flush_IF_ID = 1'b1;
        if (br_taken) begin
          pc_wrt = 1'b1;
          if (imem_done) begin
            redir_pend_d = 1'b0;
            state_d      = RUN;
          end else begin
            redir_pend_d = 1'b1;
          end
        end else if (dmem_stall) begin
          // A word arriving while IF/ID is frozen is dropped; RUN refetches the same PC.
          wrt_IF_ID   = 1'b0;
          flush_IF_ID = 1'b0;
          if (imem_done) begin
            redir_pend_d = 1'b0;
            state_d      = RUN;
          end
        end else if (imem_done) begin
          redir_pend_d = 1'b0;
          state_d      = RUN;
          if (!redir_pend_q) begin
            pc_wrt      = 1'b1;
            flush_IF_ID = 1'b0;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = RST_BUB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RST_BUB;
      bub_cnt_q    <= 3'(RST_BUBBLES);
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bub_cnt_q    <= bub_cnt_d;
      redir_pend_q <= redir_pend_d;
    end
  end

`ifdef STALL_CNT_EN
  logic stall_en;
  assign stall_en = ((state_q == RUN) || (state_q == IWAIT)) && !pc_wrt;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .cnt (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboard bench for fetch_stall_ctrl: directed scenarios plus randomized traffic
// against a behavioural model. Define STALL_CNT_EN to also check the stall counter.
module tb_fetch_stall_ctrl;

  localparam int RSTB = 2;
  localparam int CW   = 2;

  typedef struct packed {
    logic          pc_wrt;
    logic          wrt;
    logic          flush;
    logic          bub;
    logic          req;
    logic          halted;
    logic [CW-1:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_stall = 0, imem_done = 0, dmem_stall = 0, ld_use = 0, br_taken = 0, halt_id = 0;
  logic pc_wrt, wrt_IF_ID, flush_IF_ID, bubble_ID_EX, imem_req, halted;
  logic [CW-1:0] stall_cycles;

  fetch_stall_ctrl #(.RST_BUBBLES(RSTB), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_stall   (imem_stall),
    .imem_done    (imem_done),
    .dmem_stall   (dmem_stall),
    .ld_use       (ld_use),
    .br_taken     (br_taken),
    .halt_id      (halt_id),
    .pc_wrt       (pc_wrt),
    .wrt_IF_ID    (wrt_IF_ID),
    .flush_IF_ID  (flush_IF_ID),
    .bubble_ID_EX (bubble_ID_EX),
    .imem_req     (imem_req),
`ifdef STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .halted       (halted)
  );

`ifndef STALL_CNT_EN
  assign stall_cycles = '0;
`endif

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  obs_t exp_q[$];

  // Behavioural model of the front end
  int  m_bubbles_left;
  bit  m_miss_open;
  bit  m_redirect_owed;
  bit  m_is_halted;
  int  m_stalls;

  task automatic step(input bit r, input bit br, input bit dm, input bit hl,
                      input bit ld, input bit ims, input bit imd);
    obs_t e;
    bit   active;
    rst = r; br_taken = br; dmem_stall = dm; halt_id = hl;
    ld_use = ld; imem_stall = ims; imem_done = imd;
    e = '0;
    if (r) begin
      m_bubbles_left = RSTB; m_miss_open = 0; m_redirect_owed = 0;
      m_is_halted = 0; m_stalls = 0;
      e.wrt = 1; e.flush = 1;
    end else begin
      e.cnt  = CW'(m_stalls);
      active = !m_is_halted && (m_bubbles_left == 0);
      if (m_is_halted) begin
        e.halted = 1;
      end else if (m_bubbles_left > 0) begin
        e.wrt = 1; e.flush = 1;
        m_bubbles_left--;
      end else if (!m_miss_open) begin
        e.req = 1;
        if (br)       begin e.pc_wrt = 1; e.wrt = 1; e.flush = 1; end
        else if (dm)  begin end
        else if (hl)  m_is_halted = 1;
        else if (ld)  e.bub = 1;
        else if (ims) begin e.wrt = 1; e.flush = 1; m_miss_open = 1; end
        else          begin e.pc_wrt = 1; e.wrt = 1; end
      end else begin
        e.req = 1;
        if (br) e.pc_wrt = 1;
        if (dm && !br) begin
          e.wrt = 0; e.flush = 0;
        end else if (imd && !br && !m_redirect_owed) begin
          e.pc_wrt = 1; e.wrt = 1; e.flush = 0;
        end else begin
          e.wrt = 1; e.flush = 1;
        end
        if (imd) begin m_miss_open = 0; m_redirect_owed = 0; end
        else if (br) m_redirect_owed = 1;
      end
      if (active && !e.pc_wrt && m_stalls < (1 << CW) - 1) m_stalls++;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    obs_t g, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.pc_wrt = pc_wrt; g.wrt = wrt_IF_ID; g.flush = flush_IF_ID;
        g.bub = bubble_ID_EX; g.req = imem_req; g.halted = halted;
`ifdef STALL_CNT_EN
        g.cnt = stall_cycles;
`else
        g.cnt = e.cnt;
`endif
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL cycle %0d: got pc=%b wrt=%b flush=%b bub=%b req=%b halt=%b cnt=%0d, expected pc=%b wrt=%b flush=%b bub=%b req=%b halt=%b cnt=%0d",
                   cyc, g.pc_wrt, g.wrt, g.flush, g.bub, g.req, g.halted, g.cnt,
                   e.pc_wrt, e.wrt, e.flush, e.bub, e.req, e.halted, e.cnt);
        end
        cyc++;
      end
    end
  end

  initial begin : driver
    bit br, dm, hl, ld, ims, imd;
    @(posedge clk); #1;
    // reset release and bubbles
    step(1,0,0,0,0,0,0); step(1,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0); step(0,0,0,0,0,0,0); step(0,0,0,0,0,0,0);
    // three-cycle miss then delivery
    step(0,0,0,0,0,1,0); step(0,0,0,0,0,1,0); step(0,0,0,0,0,1,0);
    step(0,0,0,0,0,0,1); step(0,0,0,0,0,0,0);
    // redirect during miss, word later discarded
    step(0,0,0,0,0,1,0); step(0,1,0,0,0,0,0); step(0,0,0,0,0,0,0);
    step(0,0,0,0,0,0,1); step(0,0,0,0,0,0,0);
    // redirect coinciding with delivery
    step(0,0,0,0,0,1,0); step(0,1,0,0,0,0,1); step(0,0,0,0,0,0,0);
    // load-use with and without data stall
    step(0,0,1,0,1,0,0); step(0,0,0,0,1,0,0); step(0,0,0,0,0,0,0);
    // imem_done outside a miss is ignored
    step(0,0,0,0,0,0,1);
    // halt, stays halted, then reset
    step(0,0,0,1,0,0,0);
    for (int i = 0; i < 4; i++) step(0,1,0,0,0,1,1);
    step(1,0,0,0,0,0,0); step(0,0,0,0,0,0,0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      br  = ($urandom_range(99) < 10);
      dm  = ($urandom_range(99) < 15);
      hl  = ($urandom_range(999) < 8);
      ld  = ($urandom_range(99) < 15);
      ims = ($urandom_range(99) < 25);
      imd = ($urandom_range(99) < 30);
      if (m_is_halted && $urandom_range(9) == 0) step(1,0,0,0,0,0,0);
      else if ($urandom_range(199) == 0)         step(1,br,dm,hl,ld,ims,imd);
      else                                       step(0,br,dm,hl,ld,ims,imd);
    end
    step(0,0,0,0,0,0,0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outstanding expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
